// File: rtl/sram_fifo_prefetch.sv
// Read-side prefetch stage for a fixed-latency BRAM FIFO: turns pop/empty into a
// registered valid/ready stream and gates pops during post-reset and post-flush recovery.
module sram_fifo_prefetch #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int RD_LATENCY   = 1,
  parameter int INIT_CYCLES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic                               fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]              fifo_data_i,
  output logic                               fifo_pop_o,
  output logic                               fifo_flush_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     occupancy_o
);

  localparam int OCC_W   = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SUM_W   = $clog2(BUF_DEPTH + RD_LATENCY + 1) + 1;
  localparam int CNT_MAX = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [RD_LATENCY-1:0]   pipe;
  logic [OCC_W-1:0]        occ;
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
  logic [SUM_W-1:0]        inflight, level;
  logic                    enq, deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= INIT;
      cnt   <= CNT_W'(INIT_CYCLES);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The transition happens on the edge where the counter reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush_i) begin
      state_nxt = FLUSH;
      cnt_nxt   = CNT_W'(FLUSH_CYCLES);
    end else if (state != RUN) begin
      if (cnt <= CNT_W'(1)) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + SUM_W'(pipe[i]);
  end

  assign deq          = valid_o & ready_i;
  assign level        = SUM_W'(occ) + inflight - SUM_W'(deq);
  assign fifo_pop_o   = (state == RUN) & ~flush_i & ~fifo_empty_i & (level < SUM_W'(BUF_DEPTH));
  assign enq          = pipe[RD_LATENCY-1] & ~flush_i;
  assign fifo_flush_o = flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      pipe   <= '0;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      pipe <= (pipe << 1) | RD_LATENCY'(fifo_pop_o);
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, deq})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= fifo_data_i;
  end

  // Head is a mux of registers only; forced to zero while empty.
  assign valid_o     = (occ != '0);
  assign data_o      = valid_o ? mem[rd_ptr] : '0;
  assign occupancy_o = occ;

  a_no_full_enq: assert property (@(posedge clk_i) disable iff (rst_i)
    !(enq && (occ == OCC_W'(BUF_DEPTH))));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_pop_o && fifo_empty_i));
  a_stable_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)));

endmodule

// File: tb/tb_sram_fifo_prefetch.sv
// Bench for sram_fifo_prefetch: two instances (latency 1 / depth 2 and latency 2 / depth 3)
// fed by behavioural FIFO models, checked by a cycle table, hand sequences and scoreboards.
module tb_sram_fifo_prefetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, flush1, empty1, pop1, fflush1, valid1, ready1;
  logic [31:0] fdata1, data1;
  logic [1:0]  occ1;
  logic        rst2, flush2, empty2, pop2, fflush2, valid2, ready2;
  logic [31:0] fdata2, data2;
  logic [1:0]  occ2;

  sram_fifo_prefetch #(.DATA_WIDTH(32), .BUF_DEPTH(2), .RD_LATENCY(1),
                       .INIT_CYCLES(16), .FLUSH_CYCLES(2)) dut1 (
    .clk_i(clk), .rst_i(rst1), .flush_i(flush1), .fifo_empty_i(empty1),
    .fifo_data_i(fdata1), .fifo_pop_o(pop1), .fifo_flush_o(fflush1),
    .valid_o(valid1), .ready_i(ready1), .data_o(data1), .occupancy_o(occ1));

  sram_fifo_prefetch #(.DATA_WIDTH(32), .BUF_DEPTH(3), .RD_LATENCY(2),
                       .INIT_CYCLES(16), .FLUSH_CYCLES(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .flush_i(flush2), .fifo_empty_i(empty2),
    .fifo_data_i(fdata2), .fifo_pop_o(pop2), .fifo_flush_o(fflush2),
    .valid_o(valid2), .ready_i(ready2), .data_o(data2), .occupancy_o(occ2));

  typedef struct {
    int          push_n;
    logic [31:0] push_base;
    logic        rdy;
    logic        pop;
    logic        vld;
    logic [31:0] dat;
    logic [1:0]  occ;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] q1[$], q2[$], sb1[$], sb2[$];
  logic [31:0] dl2;
  logic        pop_s1, pop_s2, hold1, hold2;
  logic [31:0] hdata1, hdata2;
  int          n_tests, n_fail;

  function automatic vec_t mk(int pn, logic [31:0] pb, logic r, logic p, logic v,
                              logic [31:0] d, logic [1:0] o);
    vec_t t;
    t.push_n = pn; t.push_base = pb; t.rdy = r; t.pop = p; t.vld = v; t.dat = d; t.occ = o;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push1(input logic [31:0] w);
    q1.push_back(w); sb1.push_back(w); empty1 = 1'b0;
  endtask

  task automatic push2(input logic [31:0] w);
    q2.push_back(w); sb2.push_back(w); empty2 = 1'b0;
  endtask

  // Sample at the falling edge: scoreboard, hold stability, pop-vs-empty, flush effect.
  task automatic at_neg();
    @(negedge clk);
    if (valid1 === 1'b1 && ready1 === 1'b1) begin
      if (sb1.size() == 0) chk("sb1_extra", 32'(valid1), 32'(0));
      else chk("sb1_data", data1, sb1.pop_front());
    end
    if (valid2 === 1'b1 && ready2 === 1'b1) begin
      if (sb2.size() == 0) chk("sb2_extra", 32'(valid2), 32'(0));
      else chk("sb2_data", data2, sb2.pop_front());
    end
    if (hold1) begin
      chk("hold1_valid", 32'(valid1), 32'(1));
      chk("hold1_data", data1, hdata1);
    end
    if (hold2) begin
      chk("hold2_valid", 32'(valid2), 32'(1));
      chk("hold2_data", data2, hdata2);
    end
    hold1  = (valid1 === 1'b1) && (ready1 === 1'b0) && (flush1 === 1'b0);
    hold2  = (valid2 === 1'b1) && (ready2 === 1'b0) && (flush2 === 1'b0);
    hdata1 = data1;
    hdata2 = data2;
    pop_s1 = (pop1 === 1'b1);
    pop_s2 = (pop2 === 1'b1);
    if (pop_s1) chk("pop_empty1", 32'(empty1), 32'(0));
    if (pop_s2) chk("pop_empty2", 32'(empty2), 32'(0));
    if (fflush2 === 1'b1) begin
      q2.delete();
      sb2.delete();
    end
  endtask

  // Advance to just after the rising edge and update the FIFO models.
  task automatic to_next();
    @(posedge clk);
    #1;
    if (pop_s1 && q1.size() > 0) fdata1 = q1.pop_front();
    fdata2 = dl2;
    dl2    = (pop_s2 && q2.size() > 0) ? q2.pop_front() : 32'(0);
    empty1 = (q1.size() == 0);
    empty2 = (q2.size() == 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst1 = 1'b1; rst2 = 1'b1; flush1 = 1'b0; flush2 = 1'b0;
    ready1 = 1'b1; ready2 = 1'b1; empty1 = 1'b1; empty2 = 1'b1;
    fdata1 = '0; fdata2 = '0; dl2 = '0;
    pop_s1 = 1'b0; pop_s2 = 1'b0; hold1 = 1'b0; hold2 = 1'b0; hdata1 = '0; hdata2 = '0;
    for (int k = 0; k < 8; k++) push1(32'h10 + 32'(k));

    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 1, 1, 1, 32'h10 + 32'(k), 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h16, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h17, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(3, 32'h10, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h10, 1));
    for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 32'h10, 2));
    tbl.push_back(mk(0, 0, 1, 1, 1, 32'h10, 2));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h11, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h12, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    rst1 = 1'b0; rst2 = 1'b0;

    // Recovery window after reset: 16 cycles with no pop and no output.
    for (int c = 1; c <= 16; c++) begin
      at_neg();
      chk($sformatf("init%0d_pop1", c), 32'(pop1), 32'(0));
      chk($sformatf("init%0d_valid1", c), 32'(valid1), 32'(0));
      chk($sformatf("init%0d_occ1", c), 32'(occ1), 32'(0));
      chk($sformatf("init%0d_data1", c), data1, 32'(0));
      chk($sformatf("init%0d_flush1", c), 32'(fflush1), 32'(0));
      chk($sformatf("init%0d_valid2", c), 32'(valid2), 32'(0));
      to_next();
    end

    foreach (tbl[i]) begin
      ready1 = tbl[i].rdy;
      for (int n = 0; n < tbl[i].push_n; n++) push1(tbl[i].push_base + 32'(n));
      at_neg();
      chk($sformatf("tbl%0d_pop", i), 32'(pop1), 32'(tbl[i].pop));
      chk($sformatf("tbl%0d_valid", i), 32'(valid1), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_occ", i), 32'(occ1), 32'(tbl[i].occ));
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), data1, tbl[i].dat);
      to_next();
    end
    chk("sb1_drained", 32'(sb1.size()), 32'(0));

    // Flush with two words buffered and one in flight, consumer stalled.
    ready2 = 1'b0;
    for (int k = 0; k < 4; k++) push2(32'h20 + 32'(k));
    for (int t = 0; t < 3; t++) begin
      at_neg(); chk($sformatf("fl_pre%0d_pop", t), 32'(pop2), 32'(1)); to_next();
    end
    at_neg();
    chk("fl_t3_pop", 32'(pop2), 32'(0));
    chk("fl_t3_occ", 32'(occ2), 32'(1));
    to_next();
    flush2 = 1'b1;
    at_neg();
    chk("fl_t4_flush_o", 32'(fflush2), 32'(1));
    chk("fl_t4_occ", 32'(occ2), 32'(2));
    chk("fl_t4_valid", 32'(valid2), 32'(1));
    chk("fl_t4_data", data2, 32'h20);
    chk("fl_t4_pop", 32'(pop2), 32'(0));
    to_next();
    flush2 = 1'b0;
    push2(32'hA0);
    push2(32'hA1);
    at_neg();
    chk("fl_t5_occ", 32'(occ2), 32'(0));
    chk("fl_t5_valid", 32'(valid2), 32'(0));
    chk("fl_t5_flush_o", 32'(fflush2), 32'(0));
    chk("fl_t5_pop", 32'(pop2), 32'(0));
    to_next();
    at_neg(); chk("fl_t6_pop", 32'(pop2), 32'(0)); to_next();
    at_neg(); chk("fl_t7_pop", 32'(pop2), 32'(1)); to_next();
    at_neg(); chk("fl_t8_pop", 32'(pop2), 32'(1)); to_next();
    at_neg(); chk("fl_t9_valid", 32'(valid2), 32'(0)); to_next();
    at_neg();
    chk("fl_t10_valid", 32'(valid2), 32'(1));
    chk("fl_t10_data", data2, 32'hA0);
    to_next();
    ready2 = 1'b1;
    for (int t = 0; t < 10 && sb2.size() > 0; t++) begin
      at_neg(); to_next();
    end
    chk("fl_sb2_drained", 32'(sb2.size()), 32'(0));
    at_neg(); chk("fl_after_valid", 32'(valid2), 32'(0)); to_next();

    // 1000 random words with 50% consumer readiness.
    for (int k = 0; k < 1000; k++) push2(32'($urandom));
    for (int cyc = 0; cyc < 6000 && sb2.size() > 0; cyc++) begin
      ready2 = 1'($urandom_range(0, 1));
      at_neg();
      to_next();
    end
    chk("rand_sb2_left", 32'(sb2.size()), 32'(0));
    chk("rand_q2_left", 32'(q2.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
